// File: rtl/weight_renorm.sv
// Rescales each weight lane to floor(mag*SCALE/norm) using one shared restoring
// divider walked lane by lane; tag bits pass through and results clamp at 255.
module weight_renorm #(
  parameter int unsigned N      = 18,
  parameter int unsigned LANE_W = 10,
  parameter int unsigned SCALE  = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*LANE_W-1:0] weights,
  input  logic [8:0]          norm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*LANE_W-1:0] out_weights,
  output logic                sat,
  output logic                div_zero
);

  localparam int unsigned VEC_W = N * LANE_W;
  localparam int unsigned TAG_W = LANE_W - 8;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] weights_q, weights_d;
  logic [8:0]       norm_q, norm_d;
  logic [IDX_W-1:0] lane_q, lane_d;
  logic [15:0]      dividend_q, dividend_d;
  logic [9:0]       rem_q, rem_d;
  logic [14:0]      quot_q, quot_d;
  logic [3:0]       bit_q, bit_d;
  logic [VEC_W-1:0] result_q, result_d;
  logic [VEC_W-1:0] out_weights_q, out_weights_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;
  logic             div_zero_q, div_zero_d;

  logic [7:0]       lane_mag;
  logic [TAG_W-1:0] lane_tag;
  logic [10:0]      rem_shift;
  logic             rem_ge;
  logic [15:0]      quot_next;
  logic             lane_sat;
  logic [LANE_W-1:0] lane_res;

  assign in_ready = (state_q == S_IDLE);

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    weights_d     = weights_q;
    norm_d        = norm_q;
    lane_d        = lane_q;
    dividend_d    = dividend_q;
    rem_d         = rem_q;
    quot_d        = quot_q;
    bit_d         = bit_q;
    result_d      = result_q;
    out_weights_d = out_weights_q;
    out_valid_d   = out_valid_q;
    sat_d         = sat_q;
    div_zero_d    = div_zero_q;

    lane_mag = '0;
    lane_tag = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == lane_q) begin
        lane_mag = weights_q[i*LANE_W +: 8];
        lane_tag = weights_q[i*LANE_W+8 +: TAG_W];
      end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    rem_shift = {rem_q, dividend_q[15]};
    rem_ge    = (rem_shift >= {2'b00, norm_q});
    quot_next = {quot_q, rem_ge};
    lane_sat  = |quot_next[15:8];
    lane_res  = {lane_tag, lane_sat ? 8'hFF : quot_next[7:0]};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          weights_d = weights;
          norm_d    = norm;
          lane_d    = '0;
          sat_d     = 1'b0;
          if (norm == 9'd0) begin
            out_weights_d = weights;
            div_zero_d    = 1'b1;
            out_valid_d   = 1'b1;
            state_d       = S_DONE;
          end else begin
            div_zero_d = 1'b0;
            state_d    = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        dividend_d = 16'(lane_mag) * 16'(SCALE);
        rem_d      = '0;
        quot_d     = '0;
        bit_d      = 4'd15;
        state_d    = S_DIV;
      end
      S_DIV: begin
        rem_d      = rem_ge ? 10'(rem_shift - {2'b00, norm_q}) : rem_shift[9:0];
        quot_d     = quot_next[14:0];
        dividend_d = {dividend_q[14:0], 1'b0};
        bit_d      = bit_q - 4'd1;
        if (bit_q == 4'd0) begin
          for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == lane_q) result_d[i*LANE_W +: LANE_W] = lane_res;
          end
          sat_d = sat_q | lane_sat;
          if (lane_q == IDX_W'(N - 1)) begin
            out_weights_d = result_d;
            out_valid_d   = 1'b1;
            state_d       = S_DONE;
          end else begin
            lane_d  = lane_q + IDX_W'(1);
            state_d = S_SETUP;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so an aborted transaction
      // leaves no partial lane data behind.
      state_q       <= S_IDLE;
      weights_q     <= '0;
      norm_q        <= '0;
      lane_q        <= '0;
      dividend_q    <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      bit_q         <= '0;
      result_q      <= '0;
      out_weights_q <= '0;
      out_valid_q   <= 1'b0;
      sat_q         <= 1'b0;
      div_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      weights_q     <= weights_d;
      norm_q        <= norm_d;
      lane_q        <= lane_d;
      dividend_q    <= dividend_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      bit_q         <= bit_d;
      result_q      <= result_d;
      out_weights_q <= out_weights_d;
      out_valid_q   <= out_valid_d;
      sat_q         <= sat_d;
      div_zero_q    <= div_zero_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_weights = out_weights_q;
  assign sat         = sat_q;
  assign div_zero    = div_zero_q;

endmodule

// File: tb/tb_weight_renorm.sv
// Self-checking bench for weight_renorm: directed and random transactions,
// a queue-based scoreboard with a separate output monitor, and an arithmetic model.
module tb_weight_renorm;

  localparam int unsigned N      = 18;
  localparam int unsigned LANE_W = 10;
  localparam int unsigned SCALE  = 128;
  localparam int unsigned VEC_W  = N * LANE_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] weights;
  logic [8:0]       norm;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_weights;
  logic             sat;
  logic             div_zero;

  typedef struct {
    logic [VEC_W-1:0] w;
    logic             s;
    logic             d;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  weight_renorm #(.N(N), .LANE_W(LANE_W), .SCALE(SCALE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .weights     (weights),
    .norm        (norm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_weights (out_weights),
    .sat         (sat),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each lane magnitude scaled by plain integer arithmetic.
  function automatic exp_t model(input logic [VEC_W-1:0] w, input logic [8:0] n);
    exp_t e;
    int unsigned q;
    e.w = w;
    e.s = 1'b0;
    e.d = (n == 9'd0);
    if (n != 9'd0) begin
      for (int i = 0; i < N; i++) begin
        q = int'(w[i*LANE_W +: 8]) * SCALE / int'(n);
        if (q > 255) begin
          q   = 255;
          e.s = 1'b1;
        end
        e.w[i*LANE_W +: 8] = 8'(q);
      end
    end
    return e;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec(input int unsigned max_mag);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*LANE_W +: LANE_W] = {2'($urandom), 8'($urandom_range(0, max_mag))};
    return v;
  endfunction

  // Monitor: compares every presented result at the handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_weights", out_weights, e.w);
          check("sat", sat, e.s);
          check("div_zero", div_zero, e.d);
        end
      end
    end
  end

  // Called at posedge+#1 with the DUT idle or about to become idle.
  task automatic do_txn(input logic [VEC_W-1:0] w, input logic [8:0] n, input int bp);
    exp_t e;
    int   guard;
    int   lat;
    e = model(w, n);
    sb.push_back(e);
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    weights   = w;
    norm      = n;
    guard     = 0;
    while (!in_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    weights  = rand_vec(255);
    norm     = 9'($urandom);
    lat      = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (n == 9'd0) ? 0 : N * 17);
    if (bp > 0) begin
      repeat (bp) begin
        @(posedge clk); #1;
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_weights", out_weights, e.w);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [VEC_W-1:0] w;
    int seen;
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VEC_W-1:0] w;
    logic [8:0]       n;
    int               seen;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    weights   = rand_vec(255);
    norm      = 9'd5;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_weights", out_weights, '0);
    check("rst_sat", sat, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    for (int i = 0; i < N; i++) w[i*LANE_W +: LANE_W] = {2'b00, 8'd100};
    do_txn(w, 9'd200, 0);

    for (int i = 0; i < N; i++) w[i*LANE_W +: LANE_W] = {2'b00, (i == 0) ? 8'd255 : 8'd1};
    do_txn(w, 9'd1, 0);

    do_txn(rand_vec(255), 9'd0, 0);

    for (int i = 0; i < N; i++)
      w[i*LANE_W +: LANE_W] = {(i % 2 == 1) ? 2'b10 : 2'b00, 8'($urandom)};
    do_txn(w, 9'd37, 0);

    do_txn(rand_vec(255), 9'd300, 50);
    do_txn(rand_vec(255), 9'd129, 0);

    // Abort mid-division with reset; no result may appear afterwards.
    in_valid = 1'b1;
    weights  = rand_vec(255);
    norm     = 9'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (149) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_weights", out_weights, '0);
    check("abort_sat", sat, 1'b0);
    check("abort_div_zero", div_zero, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);

    do_txn(rand_vec(255), 9'd200, 0);

    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       n = 9'd0;
        1:       n = 9'($urandom_range(1, 4));
        default: n = 9'($urandom_range(1, 511));
      endcase
      do_txn(rand_vec($urandom_range(0, 1) ? 255 : 15), n, (t % 4 == 3) ? 5 : 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
